// File: rtl/demux1x8x32_buf_if.sv
// Bundle of producer and consumer signals for the 1-to-8 word distributor.
// The producer/consumer side uses the master modport, the distributor uses slave.
interface demux1x8x32_buf_if;
  // producer side
  logic [31:0] In;
  logic [2:0]  Sel;
  logic        In_valid;
  logic        In_ready;

  // consumer side, one data register per lane
  logic [31:0] Out_0;
  logic [31:0] Out_1;
  logic [31:0] Out_2;
  logic [31:0] Out_3;
  logic [31:0] Out_4;
  logic [31:0] Out_5;
  logic [31:0] Out_6;
  logic [31:0] Out_7;
  logic [7:0]  Out_valid;
  logic [7:0]  Out_ready;

  // running count of accepted input words
  logic [15:0] Accept_cnt;

  modport master (
    output In, Sel, In_valid, Out_ready,
    input  In_ready,
    input  Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7,
    input  Out_valid, Accept_cnt
  );

  modport slave (
    input  In, Sel, In_valid, Out_ready,
    output In_ready,
    output Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7,
    output Out_valid, Accept_cnt
  );
endinterface

// File: rtl/demux1x8x32_buf.sv
// Registered 1-to-8 word distributor. Each input word is steered by Sel into a
// one-entry lane buffer; every lane is drained by its own consumer handshake.
// The only combinational path is Sel/Out_valid/Out_ready -> In_ready.
module demux1x8x32_buf (
  input  logic               Clk,
  input  logic               Rst_n,
  demux1x8x32_buf_if.slave   bus
);
  localparam int unsigned LANES = 8;

  logic [31:0]      d_reg [LANES];
  logic [LANES-1:0] v_reg;
  logic [15:0]      cnt_reg;
  logic [15:0]      cnt_next;

  logic             in_ready;
  logic             acc;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drn;

  // Only the selected lane decides readiness; a full lane that is being
  // drained this cycle can take a new word in the same cycle.
  assign in_ready     = ~v_reg[bus.Sel] | bus.Out_ready[bus.Sel];
  assign acc          = bus.In_valid & in_ready;
  assign bus.In_ready = in_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign load[gi] = acc & (bus.Sel == 3'(gi));
      assign drn[gi]  = v_reg[gi] & bus.Out_ready[gi];

      // Lane buffer: a load wins over a drain (old word leaves, new one lands);
      // a drain alone only clears the valid flag and keeps the data.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          d_reg[gi] <= 32'h0;
          v_reg[gi] <= 1'b0;
        end else if (load[gi]) begin
          d_reg[gi] <= bus.In;
          v_reg[gi] <= 1'b1;
        end else if (drn[gi]) begin
          v_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign cnt_next = cnt_reg + 16'd1;

  // Accept counter, wraps modulo 2^16.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_reg <= 16'h0;
    end else if (acc) begin
      cnt_reg <= cnt_next;
    end
  end

  assign bus.Out_valid  = v_reg;
  assign bus.Accept_cnt = cnt_reg;
  assign bus.Out_0      = d_reg[0];
  assign bus.Out_1      = d_reg[1];
  assign bus.Out_2      = d_reg[2];
  assign bus.Out_3      = d_reg[3];
  assign bus.Out_4      = d_reg[4];
  assign bus.Out_5      = d_reg[5];
  assign bus.Out_6      = d_reg[6];
  assign bus.Out_7      = d_reg[7];
endmodule

// File: tb/tb_demux1x8x32_buf.sv
// Directed bench for demux1x8x32_buf with a per-lane scoreboard: accepted words
// are queued per lane and compared when the lane consumer takes them.
module tb_demux1x8x32_buf;
  logic Clk;
  logic Rst_n;

  demux1x8x32_buf_if bus ();

  demux1x8x32_buf dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] out_w [8];
  assign out_w[0] = bus.Out_0;
  assign out_w[1] = bus.Out_1;
  assign out_w[2] = bus.Out_2;
  assign out_w[3] = bus.Out_3;
  assign out_w[4] = bus.Out_4;
  assign out_w[5] = bus.Out_5;
  assign out_w[6] = bus.Out_6;
  assign out_w[7] = bus.Out_7;

  // scoreboard: words expected on each lane, oldest first
  logic [31:0] lane_q [8][$];
  logic [15:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < 8; k++) v[k] = (lane_q[k].size() != 0);
    return v;
  endfunction

  task automatic check_state(input string tag);
    chk($sformatf("%s.out_valid", tag), 32'(bus.Out_valid), 32'(model_valid()));
    chk($sformatf("%s.accept_cnt", tag), 32'(bus.Accept_cnt), 32'(exp_cnt));
  endtask

  // One clock of traffic: drive, predict, compare deliveries, clock, compare state.
  task automatic step(input string tag, input logic vld, input logic [2:0] s,
                      input logic [31:0] d, input logic [7:0] rdy);
    logic m_ready;
    bus.In_valid  = vld;
    bus.Sel       = s;
    bus.In        = d;
    bus.Out_ready = rdy;
    #1;
    m_ready = (lane_q[s].size() == 0) || rdy[s];
    chk($sformatf("%s.in_ready", tag), 32'(bus.In_ready), 32'(m_ready));
    for (int k = 0; k < 8; k++) begin
      if (lane_q[k].size() != 0 && rdy[k]) begin
        chk($sformatf("%s.deliver%0d", tag, k), out_w[k], lane_q[k][0]);
        void'(lane_q[k].pop_front());
      end
    end
    if (vld && m_ready) begin
      lane_q[s].push_back(d);
      exp_cnt = exp_cnt + 16'd1;
    end
    @(posedge Clk);
    #1;
    check_state(tag);
    $display("step %s vld=%0b sel=%0d in=%h rdy=%h -> valid=%h cnt=%h",
             tag, vld, s, d, rdy, bus.Out_valid, bus.Accept_cnt);
  endtask

  // Assert reset between edges, check the immediate effect, release at the negedge.
  task automatic do_reset(input string tag);
    @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("%s.out%0d", tag, k), out_w[k], 32'h0);
    chk($sformatf("%s.out_valid", tag), 32'(bus.Out_valid), 32'h0);
    chk($sformatf("%s.accept_cnt", tag), 32'(bus.Accept_cnt), 32'h0);
    chk($sformatf("%s.in_ready", tag), 32'(bus.In_ready), 32'h1);
    for (int k = 0; k < 8; k++) lane_q[k].delete();
    exp_cnt = 16'h0;
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    $display("reset %s done", tag);
  endtask

  initial begin
    Rst_n         = 1'b1;
    bus.In        = 32'hFFFF_FFFF;
    bus.Sel       = 3'd5;
    bus.In_valid  = 1'b1;
    bus.Out_ready = 8'h00;
    exp_cnt       = 16'h0;

    // 1. reset while a word is presented, then one accept after release
    do_reset("rst1");
    step("rst1_first", 1'b1, 3'd5, 32'hFFFF_FFFF, 8'h00);
    chk("rst1.out5", bus.Out_5, 32'hFFFF_FFFF);
    chk("rst1.valid", 32'(bus.Out_valid), 32'h20);
    chk("rst1.cnt", 32'(bus.Accept_cnt), 32'h1);

    // reset mid-operation discards the pending lane-5 word
    do_reset("rst2");

    // 2. sweep all lanes with no consumers active
    for (int k = 0; k < 8; k++)
      step($sformatf("sweep%0d", k), 1'b1, 3'(k), 32'hA000_0000 + 32'(k), 8'h00);
    chk("sweep.valid", 32'(bus.Out_valid), 32'hFF);
    chk("sweep.cnt", 32'(bus.Accept_cnt), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("sweep.out%0d", k), out_w[k], 32'hA000_0000 + 32'(k));

    // 3. back-pressure on full lane 3, then release it
    for (int i = 0; i < 4; i++) begin
      step($sformatf("bp%0d", i), 1'b1, 3'd3, 32'h1234_5678, 8'h00);
      chk("bp.out3", bus.Out_3, 32'hA000_0003);
    end
    bus.Out_ready = 8'h08;
    #1;
    chk("bp.ready_up", 32'(bus.In_ready), 32'h1);
    step("bp_rel", 1'b1, 3'd3, 32'h1234_5678, 8'h08);
    chk("bp.out3_new", bus.Out_3, 32'h1234_5678);
    chk("bp.valid3", 32'(bus.Out_valid[3]), 32'h1);

    // 4. simultaneous load and drain on lane 2
    step("ld2_a", 1'b1, 3'd2, 32'hDEAD_0001, 8'h04);
    step("ld2_b", 1'b1, 3'd2, 32'hDEAD_0002, 8'h04);
    chk("ld2.valid_b", 32'(bus.Out_valid[2]), 32'h1);
    step("ld2_c", 1'b1, 3'd2, 32'hDEAD_0003, 8'h04);
    chk("ld2.valid_c", 32'(bus.Out_valid[2]), 32'h1);
    step("ld2_drain", 1'b0, 3'd2, 32'h0, 8'h04);

    // 5. drain lane 6 and confirm its data register holds
    step("l6_load", 1'b1, 3'd6, 32'hCAFE_BABE, 8'h40);
    step("l6_drain", 1'b0, 3'd6, 32'h0, 8'h40);
    chk("l6.valid", 32'(bus.Out_valid[6]), 32'h0);
    chk("l6.hold", bus.Out_6, 32'hCAFE_BABE);
    step("l6_again", 1'b0, 3'd6, 32'h0, 8'h40);
    chk("l6.hold2", bus.Out_6, 32'hCAFE_BABE);

    // 6. counter wrap: 65537 accepts rotating over the lanes
    do_reset("rst3");
    for (int i = 0; i < 65537; i++) begin
      step("wrap", 1'b1, 3'(i), $urandom, 8'hFF);
      if (i == 65534) chk("wrap.ffff", 32'(bus.Accept_cnt), 32'h0000_FFFF);
      if (i == 65535) chk("wrap.zero", 32'(bus.Accept_cnt), 32'h0);
    end
    chk("wrap.end", 32'(bus.Accept_cnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
